mannix_job_sched: RTL and testbench
===================================

// Module: mannix_job_sched
// PURPOSE
//  Job scheduler in front of the fcc/cnn/pool accelerators. SW pushes job descriptors into an in-order command FIFO.
//  Each job is dispatched as a 1-cycle go pulse to its target unit once that unit is free; units run concurrently.
//  Per-unit done/timeout is collected and reported one at a time on a completion handshake.
// PARAMETERS
//  DEPTH        8     command FIFO entries; power of 2, >=2
//  TAG_W        8     SW job tag width
//  TIMEOUT_CYC  65536 cycles from go to forced error completion; 0 = timeout disabled
//  TMO_W        17    timeout counter width; must hold TIMEOUT_CYC
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  cmd_valid  in   1        SW job descriptor valid
//  cmd_ready  out  1        FIFO not full
//  cmd_unit   in   2        0=fcc 1=cnn 2=pool 3=barrier
//  cmd_tag    in   TAG_W    SW job id, echoed on completion
//  fcc_go     out  1        1-cycle start pulse to fcc
//  fcc_done   in   1        fcc done pulse/level
//  cnn_go     out  1        1-cycle start pulse to cnn
//  cnn_done   in   1        cnn done
//  pool_go    out  1        1-cycle start pulse to pool
//  pool_done  in   1        pool done
//  cmp_valid  out  1        completion record valid
//  cmp_ready  in   1        SW consumes completion
//  cmp_unit   out  2        unit of the completed job
//  cmp_tag    out  TAG_W    tag of the completed job
//  cmp_err    out  1        1 = timed out, 0 = normal done
//  unit_busy  out  3        {pool,cnn,fcc} state != IDLE
//  q_level    out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO emptied, all units IDLE, outputs 0 except cmd_ready=1. A job in flight at reset is dropped.
//    Late done pulses after reset are ignored (unit is IDLE).
//  FIFO: push on cmd_valid&cmd_ready. cmd_ready=0 when full, even if a pop occurs that cycle. No bypass.
//    An entry pushed in cycle N is head-visible in N+1.
//  Per-unit FSM (u=fcc,cnn,pool), with a tag register and timeout counter:
//    IDLE -> RUN  when the head targets u and is popped; u_go=1 in the next cycle only; counter cleared.
//    RUN: done is ignored in the go cycle; thereafter done=1 -> CMPL with err=0.
//      If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 without done -> CMPL with err=1.
//      done and timeout in the same cycle -> err=0.
//    CMPL -> IDLE  when this unit's record is accepted (cmp_valid&cmp_ready).
//    done while IDLE/CMPL: ignored.
//  Dispatch (in-order, max one pop per cycle):
//    Head unit 0..2: pop only if that unit is IDLE, else the head stalls and blocks later jobs.
//    Head unit 3 (barrier): pop only when all three units are IDLE; produces no go and no completion.
//  Completion: cmp_* come from a register.
//    cmp_valid is asserted while any unit is in CMPL, fixed priority fcc>cnn>pool.
//    cmp_* held stable until accepted; a higher-priority CMPL arriving while valid&!ready does not preempt.
//    Next record is presented the cycle after acceptance.
//  Minimum latency: push N -> pop N+1 -> u_go N+2; done at N+3 -> cmp_valid at N+4.
//  A unit is never re-issued before its completion is consumed (it stays in CMPL).
//  q_level counts only entries in the FIFO; popped jobs are not counted.
// TESTING
//  T1 single: push {fcc,tag=0x11} in cycle 0 -> fcc_go=1 exactly in cycle 2; fcc_done in cycle 5
//     -> cmp_valid with unit=0,tag=0x11,err=0 in cycle 6.
//  T2 concurrency/order: push cnn(0x1),pool(0x2),cnn(0x3) -> cnn_go and pool_go each once.
//     cnn(0x3) stays at the head (q_level=1) until 0x1's completion is accepted, then cnn_go again.
//  T3 simultaneous done: fcc and cnn done in the same cycle, cmp_ready=1
//     -> fcc record first, cnn record on the following cycle; unit_busy clears bit 0 then bit 1.
//  T4 timeout: TIMEOUT_CYC=16, push pool(0x7), hold pool_done=0 -> cmp_err=1, tag=0x7 at go+16.
//     done arriving later is ignored.
//  T5 barrier/full: DEPTH=8, fcc running; push barrier then 7 pool jobs -> cmd_ready=0 at q_level=8.
//     No pool_go until fcc completion is consumed.
//  T6 reset mid-run: assert rst_n=0 with cnn RUN and 3 queued -> next cycle all outputs 0, cmd_ready=1, q_level=0.
//     cnn_done after reset produces no completion.

Source files
------------

// File: rtl/mannix_job_sched_if.sv
// +-----------------------------------------------------------------------+
// | mannix_job_sched_if : SW command / completion handshake bundle        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface mannix_job_sched_if #(
   parameter int TAG_W = 8
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_unit;
   logic [TAG_W-1:0] cmd_tag;
   logic             cmp_valid;
   logic             cmp_ready;
   logic [1:0]       cmp_unit;
   logic [TAG_W-1:0] cmp_tag;
   logic             cmp_err;

   modport master (
      output cmd_valid, cmd_unit, cmd_tag, cmp_ready,
      input  cmd_ready, cmp_valid, cmp_unit, cmp_tag, cmp_err
   );

   modport slave (
      input  cmd_valid, cmd_unit, cmd_tag, cmp_ready,
      output cmd_ready, cmp_valid, cmp_unit, cmp_tag, cmp_err
   );
endinterface

`default_nettype wire

// File: rtl/mannix_job_sched.sv
// +-----------------------------------------------------------------------+
// | mannix_job_sched : in-order job FIFO dispatching to fcc/cnn/pool      |
// | with per-unit done/timeout collection and a completion handshake.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mannix_job_sched #(
   parameter int DEPTH       = 8,
   parameter int TAG_W       = 8,
   parameter int TIMEOUT_CYC = 65536,
   parameter int TMO_W       = 17
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   mannix_job_sched_if.slave           sw,
   output logic                        fcc_go,
   input  wire logic                   fcc_done,
   output logic                        cnn_go,
   input  wire logic                   cnn_done,
   output logic                        pool_go,
   input  wire logic                   pool_done,
   output logic [2:0]                  unit_busy,
   output logic [$clog2(DEPTH):0]      q_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_CMPL = 2'd2
   } unit_st_e;

   // ---------------- command FIFO ----------------
   logic [1:0]       fifo_unit_q [DEPTH];
   logic [TAG_W-1:0] fifo_tag_q  [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push, pop;
   logic [1:0]       head_unit;
   logic [TAG_W-1:0] head_tag;

   assign sw.cmd_ready = (count_q != FULL_LVL);
   assign push         = sw.cmd_valid & sw.cmd_ready;
   assign head_unit    = fifo_unit_q[rd_ptr_q];
   assign head_tag     = fifo_tag_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_unit_q[wr_ptr_q] <= sw.cmd_unit;
         fifo_tag_q[wr_ptr_q]  <= sw.cmd_tag;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // ---------------- dispatch ----------------
   logic [2:0]       unit_idle;
   logic [2:0]       cmpl_nxt;
   logic [2:0]       err_nxt;
   logic [2:0]       go_vec;
   logic [2:0]       done_vec;
   logic [TAG_W-1:0] unit_tag [3];
   logic [3:0]       can_issue;

   // Index 3 is the barrier: it may only leave the FIFO once every unit is idle.
   assign can_issue = {&unit_idle, unit_idle};
   assign pop       = (count_q != '0) & can_issue[head_unit];
   assign done_vec  = {pool_done, cnn_done, fcc_done};

   // ---------------- completion register ----------------
   logic             cmp_valid_q, cmp_valid_d;
   logic [1:0]       cmp_unit_q, cmp_unit_d;
   logic [TAG_W-1:0] cmp_tag_q, cmp_tag_d;
   logic             cmp_err_q, cmp_err_d;
   logic             cmp_fire;

   assign cmp_fire = cmp_valid_q & sw.cmp_ready;

   // ---------------- per-unit FSMs ----------------
   for (genvar i = 0; i < 3; i++) begin : g_unit
      unit_st_e         st_q, st_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic [TMO_W-1:0] cnt_q, cnt_d;
      logic             err_q, err_d;
      logic             go_q, go_d;
      logic             pop_me, accept_me, tmo_hit;

      assign pop_me    = pop & (head_unit == 2'(i));
      assign accept_me = cmp_fire & (cmp_unit_q == 2'(i));
      assign tmo_hit   = (TIMEOUT_CYC != 0) && (cnt_q == TMO_LAST);

      always_comb begin
         st_d  = st_q;
         tag_d = tag_q;
         cnt_d = cnt_q;
         err_d = err_q;
         go_d  = 1'b0;
         case (st_q)
            ST_IDLE: begin
               if (pop_me) begin
                  st_d  = ST_RUN;
                  go_d  = 1'b1;
                  tag_d = head_tag;
                  cnt_d = '0;
               end
            end
            ST_RUN: begin
               cnt_d = cnt_q + 1'b1;
               // done wins over a coincident timeout; done in the go cycle is stale
               if (!go_q && done_vec[i]) begin
                  st_d  = ST_CMPL;
                  err_d = 1'b0;
               end else if (tmo_hit) begin
                  st_d  = ST_CMPL;
                  err_d = 1'b1;
               end
            end
            ST_CMPL: begin
               if (accept_me) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q  <= ST_IDLE;
            tag_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            go_q  <= 1'b0;
         end else begin
            st_q  <= st_d;
            tag_q <= tag_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            go_q  <= go_d;
         end
      end

      assign unit_idle[i] = (st_q == ST_IDLE);
      assign cmpl_nxt[i]  = (st_d == ST_CMPL);
      assign err_nxt[i]   = err_d;
      assign unit_tag[i]  = tag_q;
      assign go_vec[i]    = go_q;
   end

   // Load from next-state so a record appears the same cycle its unit enters CMPL.
   always_comb begin
      cmp_valid_d = cmp_valid_q;
      cmp_unit_d  = cmp_unit_q;
      cmp_tag_d   = cmp_tag_q;
      cmp_err_d   = cmp_err_q;
      if (!cmp_valid_q || cmp_fire) begin
         cmp_valid_d = |cmpl_nxt;
         if (cmpl_nxt[0]) begin
            cmp_unit_d = 2'd0;
            cmp_tag_d  = unit_tag[0];
            cmp_err_d  = err_nxt[0];
         end else if (cmpl_nxt[1]) begin
            cmp_unit_d = 2'd1;
            cmp_tag_d  = unit_tag[1];
            cmp_err_d  = err_nxt[1];
         end else if (cmpl_nxt[2]) begin
            cmp_unit_d = 2'd2;
            cmp_tag_d  = unit_tag[2];
            cmp_err_d  = err_nxt[2];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_valid_q <= 1'b0;
         cmp_unit_q  <= '0;
         cmp_tag_q   <= '0;
         cmp_err_q   <= 1'b0;
      end else begin
         cmp_valid_q <= cmp_valid_d;
         cmp_unit_q  <= cmp_unit_d;
         cmp_tag_q   <= cmp_tag_d;
         cmp_err_q   <= cmp_err_d;
      end
   end

   assign sw.cmp_valid = cmp_valid_q;
   assign sw.cmp_unit  = cmp_unit_q;
   assign sw.cmp_tag   = cmp_tag_q;
   assign sw.cmp_err   = cmp_err_q;

   assign fcc_go    = go_vec[0];
   assign cnn_go    = go_vec[1];
   assign pool_go   = go_vec[2];
   assign unit_busy = ~unit_idle;
   assign q_level   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mannix_job_sched.sv
// +-----------------------------------------------------------------------+
// | tb_mannix_job_sched : scoreboard bench for mannix_job_sched           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mannix_job_sched;

   logic       clk;
   logic       rst_n;
   logic [2:0] done_drv;
   logic       fcc_go, cnn_go, pool_go;
   logic [2:0] unit_busy;
   logic [3:0] q_level;

   int n_checks = 0;
   int n_errors = 0;
   int go_cnt [3];
   logic [10:0] exp_q [$];   // {unit[1:0], err, tag[7:0]}

   mannix_job_sched_if #(.TAG_W(8)) ifc ();

   mannix_job_sched #(
      .DEPTH(8), .TAG_W(8), .TIMEOUT_CYC(16), .TMO_W(17)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (ifc),
      .fcc_go    (fcc_go),
      .fcc_done  (done_drv[0]),
      .cnn_go    (cnn_go),
      .cnn_done  (done_drv[1]),
      .pool_go   (pool_go),
      .pool_done (done_drv[2]),
      .unit_busy (unit_busy),
      .q_level   (q_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] u, input logic [7:0] t);
      int guard = 0;
      while (!ifc.cmd_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (!ifc.cmd_ready) check_val("push_ready_timeout", 32'(ifc.cmd_ready), 32'd1);
      ifc.cmd_valid = 1'b1;
      ifc.cmd_unit  = u;
      ifc.cmd_tag   = t;
      tick();
      ifc.cmd_valid = 1'b0;
   endtask

   task automatic pulse_done(input int u);
      done_drv[u] = 1'b1;
      tick();
      done_drv[u] = 1'b0;
   endtask

   task automatic wait_go(input int u);
      logic [2:0] gv;
      int g = 0;
      gv = {pool_go, cnn_go, fcc_go};
      while (!gv[u] && g < 40) begin
         tick();
         g++;
         gv = {pool_go, cnn_go, fcc_go};
      end
      check_val("go_seen", 32'(gv[u]), 32'd1);
   endtask

   // Scoreboard consumer and go-pulse counter
   always @(negedge clk) begin
      logic [10:0] rec;
      if (rst_n) begin
         if (fcc_go)  go_cnt[0]++;
         if (cnn_go)  go_cnt[1]++;
         if (pool_go) go_cnt[2]++;
         if (ifc.cmp_valid && ifc.cmp_ready) begin
            if (exp_q.size() == 0) begin
               check_val("cmp_unexpected", 32'({ifc.cmp_unit, ifc.cmp_err, ifc.cmp_tag}), 32'hFFFF_FFFF);
            end else begin
               rec = exp_q.pop_front();
               check_val("cmp_record", 32'({ifc.cmp_unit, ifc.cmp_err, ifc.cmp_tag}), 32'(rec));
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: sim time %0t exceeded limit", $time);
      n_errors++;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      go_cnt[0] = 0; go_cnt[1] = 0; go_cnt[2] = 0;
      rst_n = 1'b0;
      done_drv = 3'b000;
      ifc.cmd_valid = 1'b0;
      ifc.cmd_unit  = 2'd0;
      ifc.cmd_tag   = 8'd0;
      ifc.cmp_ready = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // reset state
      check_val("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
      check_val("rst_q_level", 32'(q_level), 32'd0);
      check_val("rst_cmp_valid", 32'(ifc.cmp_valid), 32'd0);
      check_val("rst_busy_go", 32'({unit_busy, pool_go, cnn_go, fcc_go}), 32'd0);

      // T1: single fcc job, exact latency
      ifc.cmd_valid = 1'b1; ifc.cmd_unit = 2'd0; ifc.cmd_tag = 8'h11;
      exp_q.push_back({2'd0, 1'b0, 8'h11});
      tick();                                   // cycle 1
      ifc.cmd_valid = 1'b0;
      check_val("t1_qlvl_c1", 32'(q_level), 32'd1);
      check_val("t1_go_c1", 32'(fcc_go), 32'd0);
      tick();                                   // cycle 2
      check_val("t1_go_c2", 32'(fcc_go), 32'd1);
      check_val("t1_busy_c2", 32'(unit_busy), 32'b001);
      check_val("t1_qlvl_c2", 32'(q_level), 32'd0);
      tick();                                   // cycle 3
      check_val("t1_go_c3", 32'(fcc_go), 32'd0);
      tick(); tick();                           // cycle 5
      done_drv[0] = 1'b1;
      check_val("t1_cmpv_c5", 32'(ifc.cmp_valid), 32'd0);
      tick();                                   // cycle 6
      done_drv[0] = 1'b0;
      check_val("t1_cmpv_c6", 32'(ifc.cmp_valid), 32'd1);
      check_val("t1_cmptag_c6", 32'(ifc.cmp_tag), 32'h11);
      tick();
      check_val("t1_cmpv_c7", 32'(ifc.cmp_valid), 32'd0);
      check_val("t1_busy_c7", 32'(unit_busy), 32'd0);

      // T2: concurrency and head-of-line stall
      ifc.cmp_ready = 1'b0;
      base = go_cnt[1];
      exp_q.push_back({2'd1, 1'b0, 8'h01}); push(2'd1, 8'h01);
      exp_q.push_back({2'd2, 1'b0, 8'h02}); push(2'd2, 8'h02);
      exp_q.push_back({2'd1, 1'b0, 8'h03}); push(2'd1, 8'h03);
      tick(); tick(); tick();
      check_val("t2_qlvl_stall", 32'(q_level), 32'd1);
      check_val("t2_cnn_go_once", 32'(go_cnt[1] - base), 32'd1);
      check_val("t2_pool_go_once", 32'(go_cnt[2]), 32'd1);
      pulse_done(1);
      pulse_done(2);
      tick(); tick();
      check_val("t2_held_rec", 32'({ifc.cmp_valid, ifc.cmp_unit, ifc.cmp_tag}), 32'({1'b1, 2'd1, 8'h01}));
      check_val("t2_qlvl_held", 32'(q_level), 32'd1);
      check_val("t2_cnn_no_reissue", 32'(go_cnt[1] - base), 32'd1);
      ifc.cmp_ready = 1'b1;
      tick(); tick();
      check_val("t2_cnn_go_again", 32'(cnn_go), 32'd1);
      check_val("t2_qlvl_drain", 32'(q_level), 32'd0);
      tick();
      pulse_done(1);
      tick(); tick();
      check_val("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // T3: simultaneous done, priority fcc > cnn
      exp_q.push_back({2'd0, 1'b0, 8'h21}); push(2'd0, 8'h21);
      exp_q.push_back({2'd1, 1'b0, 8'h22}); push(2'd1, 8'h22);
      tick(); tick();
      done_drv[1:0] = 2'b11;
      tick();
      done_drv[1:0] = 2'b00;
      check_val("t3_first_unit", 32'({ifc.cmp_valid, ifc.cmp_unit}), 32'({1'b1, 2'd0}));
      check_val("t3_busy_a", 32'(unit_busy), 32'b011);
      tick();
      check_val("t3_second_rec", 32'({ifc.cmp_valid, ifc.cmp_unit, ifc.cmp_tag}), 32'({1'b1, 2'd1, 8'h22}));
      check_val("t3_busy_b", 32'(unit_busy), 32'b010);
      tick();
      check_val("t3_busy_c", 32'({ifc.cmp_valid, unit_busy}), 32'd0);

      // T4: pool timeout at go+16, late done ignored
      exp_q.push_back({2'd2, 1'b1, 8'h07}); push(2'd2, 8'h07);
      tick();
      check_val("t4_go", 32'(pool_go), 32'd1);
      for (int k = 0; k < 15; k++) tick();
      check_val("t4_no_cmp_early", 32'(ifc.cmp_valid), 32'd0);
      tick();
      check_val("t4_tmo_rec", 32'({ifc.cmp_valid, ifc.cmp_err, ifc.cmp_tag}), 32'({1'b1, 1'b1, 8'h07}));
      tick();
      pulse_done(2);
      tick(); tick();
      check_val("t4_late_done", 32'({ifc.cmp_valid, unit_busy}), 32'd0);

      // T5: barrier fills FIFO while fcc runs
      base = go_cnt[2];
      exp_q.push_back({2'd0, 1'b0, 8'h30}); push(2'd0, 8'h30);
      push(2'd3, 8'hB0);
      for (int k = 0; k < 7; k++) begin
         exp_q.push_back({2'd2, 1'b0, 8'(8'h40 + k)});
         push(2'd2, 8'(8'h40 + k));
      end
      check_val("t5_full_ready", 32'(ifc.cmd_ready), 32'd0);
      check_val("t5_full_qlvl", 32'(q_level), 32'd8);
      ifc.cmd_valid = 1'b1; ifc.cmd_unit = 2'd2; ifc.cmd_tag = 8'hEE;
      tick();
      ifc.cmd_valid = 1'b0;
      check_val("t5_no_push_full", 32'(q_level), 32'd8);
      pulse_done(0);
      check_val("t5_fcc_rec", 32'({ifc.cmp_valid, ifc.cmp_unit}), 32'({1'b1, 2'd0}));
      check_val("t5_no_pool_go", 32'(go_cnt[2] - base), 32'd0);
      tick();
      check_val("t5_ready_on_pop", 32'({ifc.cmd_ready, q_level}), 32'({1'b0, 4'd8}));
      for (int k = 0; k < 7; k++) begin
         wait_go(2);
         tick();
         pulse_done(2);
      end
      tick(); tick(); tick();
      check_val("t5_drained", 32'({ifc.cmd_ready, unit_busy, q_level}), 32'({1'b1, 3'b000, 4'd0}));
      check_val("t5_sb_empty", 32'(exp_q.size()), 32'd0);

      // T6: reset mid-run drops everything
      push(2'd1, 8'h60);
      push(2'd1, 8'h61);
      push(2'd0, 8'h62);
      push(2'd2, 8'h63);
      check_val("t6_pre_state", 32'({unit_busy, q_level}), 32'({3'b010, 4'd3}));
      rst_n = 1'b0;
      tick();
      check_val("t6_rst_ready", 32'(ifc.cmd_ready), 32'd1);
      check_val("t6_rst_outs", 32'({ifc.cmp_valid, unit_busy, q_level, pool_go, cnn_go, fcc_go}), 32'd0);
      rst_n = 1'b1;
      tick();
      pulse_done(1);
      tick(); tick(); tick();
      check_val("t6_no_cmp", 32'({ifc.cmp_valid, unit_busy, q_level}), 32'd0);
      check_val("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
